codificador_instrucoes: RTL and testbench
=========================================

// Module: codificador_instrucoes
// PURPOSE
//  Encodes instruction fields into 32-bit RV32I words and writes them sequentially into the instruction memory.
//  Supported ops: ADD, OR, SLL, ADDI, LH, SH, BNE.
//  Sits in the loader/testbench path: it produces exactly the words the core's decoder consumes.
//  valid/ready input, 2-stage pipeline, word-address write counter.
// PARAMETERS
//  DEPTH   3  number of 32-bit instruction words in the target memory
//  ADDR_W  2  mem_addr width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clock     in   1        single clock, rising edge
//  reset     in   1        synchronous, active-high
//  clear     in   1        sync rewind: flush pipeline, pointer/count/erro to 0
//  in_valid  in   1        field set valid
//  in_ready  out  1        block can accept a field set
//  op        in   3        0 ADD, 1 OR, 2 SLL, 3 ADDI, 4 LH, 5 SH, 6 BNE, 7 illegal
//  rs1       in   5        source register 1
//  rs2       in   5        source register 2 (R/S/B)
//  rd        in   5        destination register (R/I)
//  imediato  in   12       immediate (I/S/B)
//  mem_we    out  1        one-cycle write strobe to instruction memory
//  mem_addr  out  ADDR_W   word address of the write
//  mem_wdata out  32       encoded instruction
//  count     out  ADDR_W+1 slots reserved (accepted legal ops) since reset/clear
//  full      out  1        count == DEPTH
//  erro      out  1        sticky: an illegal op was accepted
// BEHAVIOUR
//  - Reset (and clear): all outputs 0, both stage-valid flags 0, write pointer 0.
//    in_ready is 0 during the reset/clear cycle and 1 the cycle after.
//  - Handshake: accept when in_valid && in_ready.
//    in_ready = !full && !clear && !reset. Fields are sampled only on accept.
//  - S1 (accept cycle N): register fields and op. A legal op reserves a slot (count+1).
//    An illegal op (7) sets erro, reserves nothing and is dropped at S1.
//  - S2 (cycle N+1): encode from the S1 registers; register the result.
//    At cycle N+2: mem_we=1, mem_addr = slot index, mem_wdata = word. Latency is fixed at 2.
//    Throughput: 1 per cycle.
//  - Encoding:
//    - R (0110011): {funct7,rs2,rs1,f3,rd,op}; funct7=0. f3: ADD 000, OR 110, SLL 001.
//    - ADDI (0010011, f3 000) and LH (0000011, f3 001): {imm[11:0],rs1,f3,rd,op}.
//    - SH (0100011, f3 001) and BNE (1100011, f3 001): {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
//    - BNE uses the same 12-bit split as SH, exactly as the core decoder extracts it; no B-type bit scrambling.
//    - Unused fields (rs2 for I, rd for S/B) are ignored.
//  - Address: slot index = count value at accept. It does not wrap.
//    Once full, in_ready=0 until clear/reset. Pending writes still drain.
//  - Simultaneous clear + in_valid: clear wins, nothing accepted, in-flight S1/S2 writes are dropped (mem_we=0 next cycle).
//  - Reset mid-operation behaves like clear.
//  - mem_we is never asserted for illegal ops or while reset/clear is high.
//  - count and full update in the accept cycle's next edge, so in_ready drops the cycle after the DEPTH-th legal accept.
// STRUCTURE
//  - Package rv_isa_pkg:
//    - op enum localparams (OP_ADD..OP_BNE)
//    - opcode constants OPC_R=0110011, OPC_I=0010011, OPC_LOAD=0000011, OPC_STORE=0100011, OPC_BRANCH=1100011
//    - funct3/funct7 constants
//  - Sub-module codifica_campos: purely combinational {op,rs1,rs2,rd,imediato} -> {word,legal}.
//    It is shared with the bench reference model.
//  - This block contains only the handshake, the S1/S2 registers, the counter and the status logic.
// TESTING
//  1. ADD x3,x1,x2 -> mem_we at N+2, addr 0, wdata 0x002081B3.
//  2. ADDI x5,x0,imm 0xFFF then SH rs2=2,rs1=1,imm 8 back-to-back
//     -> 0xFFF00293 @addr0, 0x00209423 @addr1, consecutive cycles.
//  3. BNE rs1=1,rs2=2,imm 0x004 -> 0x00209263.
//     Decode the word with the core decoder: imediato=0x004, rs1=1, rs2=2.
//  4. DEPTH=3: stream 4 legal ops with in_valid held high
//     -> 3 writes (addr 0,1,2), full=1, count=3, in_ready=0, 4th not accepted.
//     Then clear -> count=0, next write at addr 0.
//  5. op=7 between two ADDs -> erro=1 (sticky), only 2 writes at addr 0,1, count=2.
//  6. Assert reset the cycle after an accept -> no mem_we ever for that op.
//     All outputs are 0 next cycle; in_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module  : rv_isa_pkg                                                        |
// | Brief   : RV32I subset constants shared by the instruction encoder.         |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

package rv_isa_pkg;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_SLL     = 3'd2;
    localparam logic [2:0] OP_ADDI    = 3'd3;
    localparam logic [2:0] OP_LH      = 3'd4;
    localparam logic [2:0] OP_SH      = 3'd5;
    localparam logic [2:0] OP_BNE     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/codifica_campos.sv
// +-----------------------------------------------------------------------------+
// | Module  : codifica_campos                                                   |
// | Brief   : Combinational field-set to RV32I word encoder.                    |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module codifica_campos
    import rv_isa_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [11:0] imediato,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op)
            OP_ADD:  word = {F7_ZERO, rs2, rs1, F3_ADD, rd, OPC_R};
            OP_OR:   word = {F7_ZERO, rs2, rs1, F3_OR,  rd, OPC_R};
            OP_SLL:  word = {F7_ZERO, rs2, rs1, F3_SLL, rd, OPC_R};
            OP_ADDI: word = {imediato, rs1, F3_ADDI, rd, OPC_I};
            OP_LH:   word = {imediato, rs1, F3_LH,   rd, OPC_LOAD};
            OP_SH:   word = {imediato[11:5], rs2, rs1, F3_SH, imediato[4:0], OPC_STORE};
            // Branch immediate uses the plain store split, matching the core decoder.
            OP_BNE:  word = {imediato[11:5], rs2, rs1, F3_BNE, imediato[4:0], OPC_BRANCH};
            default: legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/codificador_instrucoes.sv
// +-----------------------------------------------------------------------------+
// | Module  : codificador_instrucoes                                            |
// | Brief   : valid/ready field-set encoder writing RV32I words sequentially.   |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module codificador_instrucoes
    import rv_isa_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [11:0]       imediato,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              erro
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic              w_flush;
    logic              w_full;
    logic              w_accept;
    logic [31:0]       w_word;
    logic              w_legal;

    logic [ADDR_W:0]   r_count;
    logic              r_erro;

    logic              r_s1_valid;
    logic [2:0]        r_s1_op;
    logic [4:0]        r_s1_rs1;
    logic [4:0]        r_s1_rs2;
    logic [4:0]        r_s1_rd;
    logic [11:0]       r_s1_imm;
    logic [ADDR_W-1:0] r_s1_addr;

    logic              r_s2_valid;
    logic [ADDR_W-1:0] r_s2_addr;
    logic [31:0]       r_s2_word;

    assign w_flush  = reset || clear;
    assign w_full   = (r_count == c_depth);
    assign in_ready = !w_full && !w_flush;
    assign w_accept = in_valid && in_ready;

    assign count     = r_count;
    assign full      = w_full;
    assign erro      = r_erro;
    // Gated so a flush cycle never strobes the memory, even with S2 loaded.
    assign mem_we    = r_s2_valid && !w_flush;
    assign mem_addr  = r_s2_addr;
    assign mem_wdata = r_s2_word;

    // Slot reservation and sticky error status.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_count <= '0;
            r_erro  <= 1'b0;
        end else if (w_accept) begin
            if (op_is_legal(op)) begin
                r_count <= r_count + c_one;
            end else begin
                r_erro <= 1'b1;
            end
        end
    end

    // S1: capture the field set; illegal ops are dropped here.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_rd    <= '0;
            r_s1_imm   <= '0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= w_accept && op_is_legal(op);
            if (w_accept) begin
                r_s1_op   <= op;
                r_s1_rs1  <= rs1;
                r_s1_rs2  <= rs2;
                r_s1_rd   <= rd;
                r_s1_imm  <= imediato;
                r_s1_addr <= r_count[ADDR_W-1:0];
            end
        end
    end

    codifica_campos u_codifica_campos (
        .op       (r_s1_op),
        .rs1      (r_s1_rs1),
        .rs2      (r_s1_rs2),
        .rd       (r_s1_rd),
        .imediato (r_s1_imm),
        .word     (w_word),
        .legal    (w_legal)
    );

    // S2: registered encoded word presented to the memory.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_word  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && w_legal;
            if (r_s1_valid) begin
                r_s2_addr <= r_s1_addr;
                r_s2_word <= w_word;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_codificador_instrucoes.sv
// +-----------------------------------------------------------------------------+
// | Module  : tb_codificador_instrucoes                                         |
// | Brief   : Directed + random bench with a queue-based write-schedule model.  |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_codificador_instrucoes;

    localparam int DEPTH  = 3;
    localparam int ADDR_W = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        op = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [4:0]        rd = '0;
    logic [11:0]       imediato = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              erro;

    codificador_instrucoes #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imediato  (imediato),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .erro      (erro)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder built from field positions with plain arithmetic.
    function automatic logic [31:0] ref_word(input int o, input int a, input int b,
                                             input int d, input int im);
        longint w;
        int opc;
        int f3;
        w = 0;
        case (o)
            0: begin opc = 'h33; f3 = 0; end
            1: begin opc = 'h33; f3 = 6; end
            2: begin opc = 'h33; f3 = 1; end
            3: begin opc = 'h13; f3 = 0; end
            4: begin opc = 'h03; f3 = 1; end
            5: begin opc = 'h23; f3 = 1; end
            default: begin opc = 'h63; f3 = 1; end
        endcase
        if (o <= 2)
            w = opc + d * 128 + f3 * 4096 + a * 32768 + longint'(b) * (64'd1 << 20);
        else if (o <= 4)
            w = opc + d * 128 + f3 * 4096 + a * 32768 + longint'(im) * (64'd1 << 20);
        else
            w = opc + (im % 32) * 128 + f3 * 4096 + a * 32768 + longint'(b) * (64'd1 << 20)
                + longint'(im / 32) * (64'd1 << 25);
        return w[31:0];
    endfunction

    typedef struct {
        int          due;
        int          addr;
        logic [31:0] word;
    } wr_t;

    wr_t q[$];
    int  cyc   = 0;
    int  m_cnt = 0;
    bit  m_erro = 1'b0;

    // Model: every accepted legal op is scheduled to appear one interval after the next edge.
    always @(posedge clock) begin
        cyc++;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        if (reset || clear) begin
            q.delete();
            m_cnt  = 0;
            m_erro = 1'b0;
        end else if (in_valid && m_cnt < DEPTH) begin
            if (op == 3'd7) begin
                m_erro = 1'b1;
            end else begin
                q.push_back('{due: cyc + 1, addr: m_cnt,
                              word: ref_word(int'(op), int'(rs1), int'(rs2), int'(rd), int'(imediato))});
                m_cnt++;
            end
        end
    end

    always @(negedge clock) begin
        bit exp_we;
        exp_we = (q.size() > 0) && (q[0].due == cyc) && !reset && !clear;
        check_val("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            check_val("mem_addr", 32'(mem_addr), 32'(q[0].addr));
            check_val("mem_wdata", mem_wdata, q[0].word);
        end
        check_val("count", 32'(count), 32'(m_cnt));
        check_val("full", 32'(full), 32'(m_cnt == DEPTH));
        check_val("erro", 32'(erro), 32'(m_erro));
        check_val("in_ready", 32'(in_ready), 32'(m_cnt < DEPTH && !clear && !reset));
        if (mem_we) n_writes++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [11:0] im);
        in_valid = 1'b1;
        op = o; rs1 = a; rs2 = b; rd = d; imediato = im;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        rd = 5'($urandom); imediato = 12'($urandom);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_write(input string tag, input int exp_addr, input logic [31:0] exp_word,
                              input int exp_lat, output logic [31:0] got_word);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        got_word = '0;
        while (n < 6 && !found) begin
            @(negedge clock);
            n++;
            if (mem_we) found = 1'b1;
        end
        check_val({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            got_word = mem_wdata;
            check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
            check_val({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
            check_val({tag, "_wdata"}, mem_wdata, exp_word);
        end
    endtask

    initial begin
        logic [31:0] w;
        int w0;

        @(negedge clock);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        #1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD x3,x1,x2
        send(3'd0, 5'd1, 5'd2, 5'd3, 12'h000);
        wait_write("t1", 0, 32'h002081B3, 2, w);

        // ADDI then SH back-to-back
        do_clear();
        send(3'd3, 5'd0, 5'd0, 5'd5, 12'hFFF);
        send(3'd5, 5'd1, 5'd2, 5'd0, 12'h008);
        wait_write("t2a", 0, 32'hFFF00293, 1, w);
        wait_write("t2b", 1, 32'h00209423, 1, w);

        // BNE, then decode with the core's field split
        do_clear();
        send(3'd6, 5'd1, 5'd2, 5'd0, 12'h004);
        wait_write("t3", 0, 32'h00209263, 2, w);
        check_val("t3_dec_imm", 32'({w[31:25], w[11:7]}), 32'h004);
        check_val("t3_dec_rs1", 32'(w[19:15]), 32'd1);
        check_val("t3_dec_rs2", 32'(w[24:20]), 32'd2);

        // Fill with in_valid held high: fourth op must be refused
        do_clear();
        w0 = n_writes;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 3'd0; rs1 = 5'(i + 1); rs2 = 5'(i + 7); rd = 5'(i + 20);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check_val("t4_writes", 32'(n_writes - w0), 32'd3);
        check_val("t4_count", 32'(count), 32'd3);
        check_val("t4_full", 32'(full), 32'd1);
        check_val("t4_in_ready", 32'(in_ready), 32'd0);
        do_clear();
        check_val("t4_clr_count", 32'(count), 32'd0);
        send(3'd1, 5'd4, 5'd5, 5'd6, 12'h000);
        wait_write("t4c", 0, ref_word(1, 4, 5, 6, 0), 2, w);

        // Illegal op between two ADDs
        do_clear();
        w0 = n_writes;
        send(3'd0, 5'd1, 5'd2, 5'd3, 12'h000);
        send(3'd7, 5'd9, 5'd9, 5'd9, 12'h123);
        send(3'd0, 5'd4, 5'd5, 5'd6, 12'h000);
        repeat (3) tick();
        check_val("t5_erro", 32'(erro), 32'd1);
        check_val("t5_writes", 32'(n_writes - w0), 32'd2);
        check_val("t5_count", 32'(count), 32'd2);

        // Reset the cycle after an accept: the op must never be written
        w0 = n_writes;
        send(3'd2, 5'd7, 5'd8, 5'd9, 12'h000);
        reset = 1'b1;
        @(negedge clock);
        check_val("t6_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_val("t6_mem_we", 32'(mem_we), 32'd0);
        check_val("t6_mem_addr", 32'(mem_addr), 32'd0);
        check_val("t6_mem_wdata", mem_wdata, 32'd0);
        check_val("t6_count", 32'(count), 32'd0);
        check_val("t6_erro", 32'(erro), 32'd0);
        check_val("t6_in_ready", 32'(in_ready), 32'd1);
        repeat (3) tick();
        check_val("t6_writes", 32'(n_writes - w0), 32'd0);

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset    = (r < 2);
            clear    = (r >= 2 && r < 12);
            in_valid = ($urandom_range(0, 99) < 75);
            op       = ($urandom_range(0, 99) < 10) ? 3'd7 : 3'($urandom_range(0, 6));
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            rd       = 5'($urandom);
            imediato = 12'($urandom);
            tick();
        end
        reset = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
